// File: rtl/dnn_fixed_pkg.sv
// Shared signed fixed-point definitions for the z accumulator and the
// sigmoid / sigmoid-prime lookup tables that consume its result.
package dnn_fixed_pkg;

  // Q-format of every word on the datapath (sign bit included in WIDTH).
  localparam int WIDTH     = 16;
  localparam int INT_BITS  = 3;
  localparam int FRAC_BITS = 12;

  // Extra accumulator MSBs: up to 2**GUARD terms can be summed without wrap.
  localparam int GUARD     = 8;
  localparam int ACC_W     = WIDTH + FRAC_BITS + GUARD;

  // Fixed-point constants.
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp a wide signed accumulator value into a WIDTH-bit signed word.
  // Values above SAT_MAX clamp to SAT_MAX, values below SAT_MIN clamp to
  // SAT_MIN, everything else is passed through by truncation.
  function automatic logic [WIDTH-1:0] sat_to_width(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    logic [WIDTH-1:0]        r;
    hi = {{(ACC_W-WIDTH){1'b0}}, SAT_MAX};
    lo = {{(ACC_W-WIDTH){1'b1}}, SAT_MIN};
    if (v > hi) begin
      r = SAT_MAX;
    end else if (v < lo) begin
      r = SAT_MIN;
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fx_mult.sv
// Combinational signed fixed-point multiplier. The full 2*WIDTH product is
// realigned to the Q-format by dropping FRAC_BITS fraction bits (floor, i.e.
// rounding toward -inf) and sign-extended to the accumulator width.
module fx_mult
  import dnn_fixed_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  output logic [ACC_W-1:0] p
);

  localparam int PROD_W  = 2 * WIDTH;
  localparam int ALIGN_W = PROD_W - FRAC_BITS;

  logic signed [PROD_W-1:0] prod_s;
  logic                     unused_frac_s;

  // Full-precision signed product, then floor-align by taking the upper bits.
  always_comb begin
    prod_s        = PROD_W'($signed(a)) * PROD_W'($signed(w));
    p             = {{(ACC_W-ALIGN_W){prod_s[PROD_W-1]}}, prod_s[PROD_W-1:FRAC_BITS]};
    unused_frac_s = ^prod_s[FRAC_BITS-1:0];
  end

endmodule

// File: rtl/z_accum.sv
// Neuron pre-activation accumulator: z = sat(bias + sum(a_i * w_i)) built
// from a valid/ready stream of (activation, weight) terms, presented on a
// valid/ready output that feeds the sigmoid tables directly.
module z_accum
  import dnn_fixed_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] bias,
  output logic             z_valid,
  input  logic             z_ready,
  output logic [WIDTH-1:0] z
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [WIDTH-1:0] z_r;
  logic [WIDTH-1:0] z_nxt_s;
  logic             z_valid_r;

  logic             in_ready_s;
  logic             in_beat_s;
  logic             out_beat_s;
  logic [WIDTH-1:0] a_gated_s;
  logic [WIDTH-1:0] w_gated_s;
  logic [ACC_W-1:0] p_s;
  logic [ACC_W-1:0] bias_ext_s;
  logic [ACC_W-1:0] start_sum_s;
  logic [ACC_W-1:0] sum_s;

  // Operands are forced to zero while no term is offered so undefined
  // inputs never reach the multiplier or the adder.
  always_comb begin
    if (in_valid) begin
      a_gated_s = a;
      w_gated_s = w;
    end else begin
      a_gated_s = {WIDTH{1'b0}};
      w_gated_s = {WIDTH{1'b0}};
    end
  end

  fx_mult u_mult (
    .a (a_gated_s),
    .w (w_gated_s),
    .p (p_s)
  );

  // Input acceptance: always open while summing, tied to the consumer while
  // a result is held so a new vector can start in the same cycle it leaves.
  always_comb begin
    case (state_r)
      ST_IDLE:  in_ready_s = 1'b1;
      ST_ACCUM: in_ready_s = 1'b1;
      ST_HOLD:  in_ready_s = z_ready;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Handshake decodes and the two candidate sums (restart vs. continue).
  always_comb begin
    in_beat_s   = in_valid & in_ready_s;
    out_beat_s  = z_valid_r & z_ready;
    bias_ext_s  = {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};
    start_sum_s = bias_ext_s + p_s;
    if (in_first) begin
      sum_s = start_sum_s;
    end else begin
      sum_s = acc_r + p_s;
    end
  end

  // Next-state logic: accumulate terms, saturate into z on the final term,
  // and hold the result until the consumer takes it.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    z_nxt_s     = z_r;
    case (state_r)
      ST_IDLE: begin
        // Terms that do not open a vector are dropped.
        if (in_beat_s && in_first) begin
          acc_nxt_s = start_sum_s;
          if (in_last) begin
            state_nxt_s = ST_HOLD;
            z_nxt_s     = sat_to_width(start_sum_s);
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // A stray in_first restarts the sum and drops the partial result.
        if (in_beat_s) begin
          acc_nxt_s = sum_s;
          if (in_last) begin
            state_nxt_s = ST_HOLD;
            z_nxt_s     = sat_to_width(sum_s);
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_beat_s) begin
          if (in_beat_s && in_first) begin
            acc_nxt_s = start_sum_s;
            if (in_last) begin
              state_nxt_s = ST_HOLD;
              z_nxt_s     = sat_to_width(start_sum_s);
            end else begin
              state_nxt_s = ST_ACCUM;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        acc_nxt_s   = {ACC_W{1'b0}};
        z_nxt_s     = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, accumulator and output registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= {ACC_W{1'b0}};
      z_r       <= {WIDTH{1'b0}};
      z_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      z_r       <= z_nxt_s;
      z_valid_r <= (state_nxt_s == ST_HOLD);
    end
  end

  assign in_ready = in_ready_s;
  assign z_valid  = z_valid_r;
  assign z        = z_r;

endmodule

// File: tb/tb_z_accum.sv
// Directed bench for z_accum: stimulus pushes expected z values into a
// queue, an independent monitor pops and compares on every output beat.
module tb_z_accum;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_first;
  logic        in_last;
  logic [15:0] a;
  logic [15:0] w;
  logic [15:0] bias;
  logic        z_valid;
  logic        z_ready;
  logic [15:0] z;

  int          total;
  int          bad;
  logic [15:0] exp_q[$];

  z_accum dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_last  (in_last),
    .a        (a),
    .w        (w),
    .bias     (bias),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z        (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  // Monitor: every output beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && z_valid && z_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got z=%h want no output", z);
      end else begin
        chk("sb_z", {16'h0000, z}, {16'h0000, exp_q.pop_front()});
      end
    end
  end

  // Drive one term; called and returning at posedge+1. When exp_out is set
  // the expected z is queued and the one-cycle latency is checked.
  task automatic send_beat(input logic f, input logic l, input logic [15:0] av,
                           input logic [15:0] wv, input logic [15:0] bv,
                           input logic exp_out, input logic [15:0] exp_z,
                           input string name);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    a        = av;
    w        = wv;
    bias     = bv;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got in_ready=0 want 1 within 20 cycles", name);
    end
    if (exp_out) begin
      chk({name, "_pre_valid"}, {31'd0, z_valid}, 32'd0);
      exp_q.push_back(exp_z);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    a        = 16'hxxxx;
    w        = 16'hxxxx;
    bias     = 16'hxxxx;
    if (exp_out) begin
      chk({name, "_latency"}, {31'd0, z_valid}, 32'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1);
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    a        = 16'h0000;
    w        = 16'h0000;
    bias     = 16'h0000;
    z_ready  = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_z_valid", {31'd0, z_valid}, 32'd0);
    chk("rst_z", {16'h0000, z}, 32'h0000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // T1: single term 0.5 + 1*2
    send_beat(1'b1, 1'b1, 16'h1000, 16'h2000, 16'h0800, 1'b1, 16'h2800, "t1");
    idle(2);

    // T2: four terms of 1*0.25
    send_beat(1'b1, 1'b0, 16'h1000, 16'h0400, 16'h0000, 1'b0, 16'h0000, "t2a");
    send_beat(1'b0, 1'b0, 16'h1000, 16'h0400, 16'h0000, 1'b0, 16'h0000, "t2b");
    send_beat(1'b0, 1'b0, 16'h1000, 16'h0400, 16'h0000, 1'b0, 16'h0000, "t2c");
    send_beat(1'b0, 1'b1, 16'h1000, 16'h0400, 16'h0000, 1'b1, 16'h1000, "t2d");
    idle(2);

    // T3: positive and negative saturation
    send_beat(1'b1, 1'b0, 16'h2000, 16'h2000, 16'h0000, 1'b0, 16'h0000, "t3a");
    send_beat(1'b0, 1'b0, 16'h2000, 16'h2000, 16'h0000, 1'b0, 16'h0000, "t3b");
    send_beat(1'b0, 1'b0, 16'h2000, 16'h2000, 16'h0000, 1'b0, 16'h0000, "t3c");
    send_beat(1'b0, 1'b1, 16'h2000, 16'h2000, 16'h0000, 1'b1, 16'h7FFF, "t3d");
    idle(2);
    send_beat(1'b1, 1'b1, 16'hE000, 16'h3000, 16'hD000, 1'b1, 16'h8000, "t3neg");
    idle(2);

    // T4: floor alignment of the product
    send_beat(1'b1, 1'b1, 16'h0001, 16'h0800, 16'h0000, 1'b1, 16'h0000, "t4pos");
    idle(2);
    send_beat(1'b1, 1'b1, 16'hFFFF, 16'h0800, 16'h0000, 1'b1, 16'hFFFF, "t4neg");
    idle(2);

    // T5: backpressure, then release together with a new first term
    z_ready = 1'b0;
    send_beat(1'b1, 1'b1, 16'h1000, 16'h1000, 16'h0100, 1'b1, 16'h1100, "t5a");
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_valid", {31'd0, z_valid}, 32'd1);
      chk("t5_hold_z", {16'h0000, z}, 32'h0000_1100);
      chk("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    z_ready = 1'b1;
    send_beat(1'b1, 1'b0, 16'h1000, 16'h0800, 16'h0000, 1'b0, 16'h0000, "t5b");
    chk("t5_left_hold", {31'd0, z_valid}, 32'd0);
    send_beat(1'b0, 1'b1, 16'h1000, 16'h0800, 16'h0000, 1'b1, 16'h1000, "t5c");
    idle(2);

    // T6: asynchronous reset mid-vector
    send_beat(1'b1, 1'b0, 16'h1000, 16'h1000, 16'h0000, 1'b0, 16'h0000, "t6a");
    send_beat(1'b0, 1'b0, 16'h1000, 16'h1000, 16'h0000, 1'b0, 16'h0000, "t6b");
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_z_valid", {31'd0, z_valid}, 32'd0);
    chk("t6_rst_z", {16'h0000, z}, 32'h0000_0000);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(1'b0, 1'b1, 16'h1000, 16'h1000, 16'h0000, 1'b0, 16'h0000, "t6stray");
    chk("t6_stray_ignored", {31'd0, z_valid}, 32'd0);
    send_beat(1'b1, 1'b0, 16'h1000, 16'h1000, 16'h0200, 1'b0, 16'h0000, "t6c");
    send_beat(1'b0, 1'b1, 16'h0800, 16'h1000, 16'h0000, 1'b1, 16'h1A00, "t6d");
    idle(3);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
